l1b_buyruk_onbellegi: RTL and testbench

Direct-mapped L1 instruction cache sitting directly upstream of the fetch stage (`getir`). It accepts word-aligned fetch addresses from `getir`, returns a 32-bit instruction word one cycle later on a hit, and stalls `getir` during a miss while it refills one line from main memory over a simple request/beat handshake. It also supports full invalidation, for `fence.i`, and cancellation of an in-flight response on pipeline flush.

---
 rtl/l1b_buyruk_onbellegi_pkg.sv | 16 +
 rtl/l1b_buyruk_onbellegi_if.sv | 36 +++
 rtl/l1b_buyruk_onbellegi_etiket_dizisi.sv | 44 ++++
 rtl/l1b_buyruk_onbellegi.sv | 146 ++++++++++++++
 tb/tb_l1b_buyruk_onbellegi.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1b_buyruk_onbellegi_pkg.sv
// Shared constants and FSM state type for the L1 instruction cache.
package l1b_buyruk_onbellegi_pkg;

  localparam int L1B_PS_BIT       = 32;
  localparam int L1B_BUYRUK_BIT   = 32;
  localparam int L1B_SATIR_SAYISI = 64;
  localparam int L1B_SATIR_KELIME = 4;

  typedef enum logic [1:0] {
    L1B_HAZIR  = 2'd0,
    L1B_ISTE   = 2'd1,
    L1B_DOLDUR = 2'd2,
    L1B_YANIT  = 2'd3
  } l1b_durum_e;

endpackage

// File: rtl/l1b_buyruk_onbellegi_if.sv
// Fetch-side and memory-side handshake bundle of the L1 instruction cache.
interface l1b_buyruk_onbellegi_if #(
  parameter int ADRES_BIT = l1b_buyruk_onbellegi_pkg::L1B_PS_BIT
);
  import l1b_buyruk_onbellegi_pkg::*;

  logic [ADRES_BIT-1:0]      getir_ps_i;
  logic                      getir_ps_gecerli_i;
  logic                      getir_adres_kabul_o;
  logic                      getir_hazir_o;
  logic                      getir_duraklat_o;
  logic [L1B_BUYRUK_BIT-1:0] getir_buy_o;
  logic                      getir_gecerli_o;
  logic                      getir_iptal_i;
  logic                      gecersiz_kil_i;
  logic [ADRES_BIT-1:0]      bellek_adres_o;
  logic                      bellek_gecerli_o;
  logic                      bellek_hazir_i;
  logic [L1B_BUYRUK_BIT-1:0] bellek_veri_i;
  logic                      bellek_veri_gecerli_i;

  modport slave (
    input  getir_ps_i, getir_ps_gecerli_i, getir_iptal_i, gecersiz_kil_i,
           bellek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i,
    output getir_adres_kabul_o, getir_hazir_o, getir_duraklat_o, getir_buy_o,
           getir_gecerli_o, bellek_adres_o, bellek_gecerli_o
  );

  modport master (
    output getir_ps_i, getir_ps_gecerli_i, getir_iptal_i, gecersiz_kil_i,
           bellek_hazir_i, bellek_veri_i, bellek_veri_gecerli_i,
    input  getir_adres_kabul_o, getir_hazir_o, getir_duraklat_o, getir_buy_o,
           getir_gecerli_o, bellek_adres_o, bellek_gecerli_o
  );

endinterface

// File: rtl/l1b_buyruk_onbellegi_etiket_dizisi.sv
// Valid and tag arrays of the L1 instruction cache: combinational hit lookup,
// one write port and a flash-clear of all valid bits.
module l1b_etiket_dizisi
  import l1b_buyruk_onbellegi_pkg::*;
#(
  parameter int SATIR_SAYISI = L1B_SATIR_SAYISI,
  parameter int IDX_BIT      = $clog2(SATIR_SAYISI),
  parameter int ETK_BIT      = 22
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IDX_BIT-1:0] ara_idx_i,
  input  logic [ETK_BIT-1:0] ara_etk_i,
  output logic               isabet_o,
  input  logic               yaz_i,
  input  logic [IDX_BIT-1:0] yaz_idx_i,
  input  logic [ETK_BIT-1:0] yaz_etk_i,
  input  logic               temizle_i
);

  logic [SATIR_SAYISI-1:0] gecerli_q, gecerli_d;
  logic [ETK_BIT-1:0]      etiket_q [SATIR_SAYISI];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gecerli_d = gecerli_q;
    if (temizle_i)  gecerli_d            = '0;
    else if (yaz_i) gecerli_d[yaz_idx_i] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) gecerli_q <= '0;
    else       gecerli_q <= gecerli_d;
  end

  // NOTE: storage arrays are not reset; the valid bits alone decide whether contents are used.
  always_ff @(posedge clk_i) begin
    if (yaz_i) etiket_q[yaz_idx_i] <= yaz_etk_i;
  end

  assign isabet_o = gecerli_q[ara_idx_i] && (etiket_q[ara_idx_i] == ara_etk_i);

endmodule

// File: rtl/l1b_buyruk_onbellegi.sv
// Direct-mapped L1 instruction cache in front of the fetch stage: one-cycle hits,
// stalling line refill over a request/beat memory handshake, invalidate and flush.
module l1b_buyruk_onbellegi
  import l1b_buyruk_onbellegi_pkg::*;
#(
  parameter int SATIR_SAYISI = L1B_SATIR_SAYISI,
  parameter int SATIR_KELIME = L1B_SATIR_KELIME,
  parameter int PS_BIT       = L1B_PS_BIT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  l1b_buyruk_onbellegi_if.slave bus
);

  localparam int OFS_BIT = $clog2(SATIR_KELIME);
  localparam int IDX_BIT = $clog2(SATIR_SAYISI);
  localparam int ETK_BIT = PS_BIT - IDX_BIT - OFS_BIT - 2;

  l1b_durum_e                durum_q, durum_d;
  logic [PS_BIT-1:0]         adres_q, adres_d;
  logic [OFS_BIT-1:0]        sayac_q, sayac_d;
  logic                      dusur_q, dusur_d;
  logic                      bekleyen_q, bekleyen_d;
  logic                      gecerli_q, gecerli_d;
  logic [L1B_BUYRUK_BIT-1:0] buy_q, buy_d;
  logic [L1B_BUYRUK_BIT-1:0] veri_q [SATIR_SAYISI][SATIR_KELIME];

  logic               kabul, isabet, temizle, etk_yaz, veri_yaz;
  logic [OFS_BIT-1:0] ps_ofs, a_ofs;
  logic [IDX_BIT-1:0] ps_idx, a_idx;
  logic [ETK_BIT-1:0] ps_etk, a_etk;

  assign ps_ofs = bus.getir_ps_i[OFS_BIT+1:2];
  assign ps_idx = bus.getir_ps_i[IDX_BIT+OFS_BIT+1:OFS_BIT+2];
  assign ps_etk = bus.getir_ps_i[PS_BIT-1:IDX_BIT+OFS_BIT+2];
  assign a_ofs  = adres_q[OFS_BIT+1:2];
  assign a_idx  = adres_q[IDX_BIT+OFS_BIT+1:OFS_BIT+2];
  assign a_etk  = adres_q[PS_BIT-1:IDX_BIT+OFS_BIT+2];

  l1b_etiket_dizisi #(
    .SATIR_SAYISI(SATIR_SAYISI),
    .IDX_BIT     (IDX_BIT),
    .ETK_BIT     (ETK_BIT)
  ) u_etiket (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ara_idx_i(ps_idx),
    .ara_etk_i(ps_etk),
    .isabet_o (isabet),
    .yaz_i    (etk_yaz),
    .yaz_idx_i(a_idx),
    .yaz_etk_i(a_etk),
    .temizle_i(temizle)
  );

  always_comb begin
    durum_d    = durum_q;
    adres_d    = adres_q;
    sayac_d    = sayac_q;
    dusur_d    = dusur_q;
    bekleyen_d = bekleyen_q;
    gecerli_d  = 1'b0;
    buy_d      = buy_q;
    kabul      = 1'b0;
    temizle    = 1'b0;
    etk_yaz    = 1'b0;
    veri_yaz   = 1'b0;

    unique case (durum_q)
      L1B_HAZIR: begin
        dusur_d = 1'b0;
        kabul   = bus.getir_ps_gecerli_i && !bus.gecersiz_kil_i && !bekleyen_q;
        if (bus.gecersiz_kil_i || bekleyen_q) begin
          temizle    = 1'b1;
          bekleyen_d = 1'b0;
        end
        if (kabul && isabet) begin
          buy_d     = veri_q[ps_idx][ps_ofs];
          gecerli_d = 1'b1;
        end else if (kabul) begin
          adres_d = bus.getir_ps_i;
          durum_d = L1B_ISTE;
        end
      end
      L1B_ISTE: begin
        if (bus.bellek_hazir_i) begin
          durum_d = L1B_DOLDUR;
          sayac_d = '0;
        end
      end
      L1B_DOLDUR: begin
        if (bus.bellek_veri_gecerli_i) begin
          veri_yaz = 1'b1;
          sayac_d  = sayac_q + 1'b1;
          // The requested word may be the beat arriving right now, not yet in the array.
          if (sayac_q == OFS_BIT'(SATIR_KELIME - 1)) begin
            etk_yaz   = 1'b1;
            durum_d   = L1B_YANIT;
            buy_d     = (a_ofs == sayac_q) ? bus.bellek_veri_i : veri_q[a_idx][a_ofs];
            gecerli_d = !(dusur_q || bus.getir_iptal_i);
          end
        end
      end
      L1B_YANIT: durum_d = L1B_HAZIR;
      default:   durum_d = L1B_HAZIR;
    endcase

    if ((durum_q == L1B_ISTE || durum_q == L1B_DOLDUR) && bus.getir_iptal_i) dusur_d = 1'b1;
    if (durum_q != L1B_HAZIR && bus.gecersiz_kil_i) bekleyen_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q    <= L1B_HAZIR;
      adres_q    <= '0;
      sayac_q    <= '0;
      dusur_q    <= 1'b0;
      bekleyen_q <= 1'b0;
      gecerli_q  <= 1'b0;
      buy_q      <= '0;
    end else begin
      durum_q    <= durum_d;
      adres_q    <= adres_d;
      sayac_q    <= sayac_d;
      dusur_q    <= dusur_d;
      bekleyen_q <= bekleyen_d;
      gecerli_q  <= gecerli_d;
      buy_q      <= buy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (veri_yaz) veri_q[a_idx][sayac_q] <= bus.bellek_veri_i;
  end

  assign bus.getir_adres_kabul_o = kabul;
  assign bus.getir_hazir_o       = (durum_q == L1B_HAZIR);
  assign bus.getir_duraklat_o    = (durum_q != L1B_HAZIR);
  assign bus.getir_buy_o         = buy_q;
  assign bus.getir_gecerli_o     = gecerli_q && !bus.getir_iptal_i;
  assign bus.bellek_gecerli_o    = (durum_q == L1B_ISTE);
  assign bus.bellek_adres_o      = (durum_q == L1B_ISTE)
                                   ? {adres_q[PS_BIT-1:OFS_BIT+2], {(OFS_BIT+2){1'b0}}}
                                   : '0;

endmodule

// File: tb/tb_l1b_buyruk_onbellegi.sv
// Self-checking bench for l1b_buyruk_onbellegi: scoreboard of expected fetch
// responses, a scripted memory responder and one task per scenario.
module tb_l1b_buyruk_onbellegi;
  import l1b_buyruk_onbellegi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1b_buyruk_onbellegi_if bus ();

  l1b_buyruk_onbellegi dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] beklenen_q[$];
  logic [31:0] mon_e;

  always @(posedge clk) cyc++;

  // Line 0x100 holds 0x11,0x22,0x33,0x44; everything else is a tagged address pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h000_0010) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return 32'hC0DE_0000 | {16'd0, a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.getir_gecerli_o === 1'b1) begin
      tests++;
      if (beklenen_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_response got=%h expected=none", bus.getir_buy_o);
      end else begin
        mon_e = beklenen_q.pop_front();
        if (bus.getir_buy_o !== mon_e) begin
          fails++;
          $display("FAIL response_data got=%h expected=%h", bus.getir_buy_o, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic req(input logic [31:0] a, input bit push);
    bus.getir_ps_i         = a;
    bus.getir_ps_gecerli_i = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.getir_adres_kabul_o !== 1'b1) begin
      fails++;
      $display("FAIL req_kabul addr=%h got=%b expected=1", a, bus.getir_adres_kabul_o);
    end
    if (push) beklenen_q.push_back(mem_word(a));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.getir_ps_gecerli_i = 1'b0;
  endtask

  task automatic serve_refill(input logic [31:0] line, input int gap, input int iptal_beat,
                              input bit gk_in_iste);
    int k = 0;
    while (bus.bellek_gecerli_o !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (bus.bellek_gecerli_o !== 1'b1) begin
      fails++;
      $display("FAIL refill_request got=%b expected=1 (timeout)", bus.bellek_gecerli_o);
      return;
    end
    tests++;
    if (bus.bellek_adres_o !== line) begin
      fails++;
      $display("FAIL refill_addr got=%h expected=%h", bus.bellek_adres_o, line);
    end
    bus.gecersiz_kil_i = gk_in_iste;
    bus.bellek_hazir_i = 1'b1;
    @(posedge clk);
    #1;
    bus.bellek_hazir_i = 1'b0;
    bus.gecersiz_kil_i = 1'b0;
    for (int i = 0; i < L1B_SATIR_KELIME; i++) begin
      repeat (gap) begin
        bus.bellek_veri_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
      end
      bus.bellek_veri_i         = mem_word(line + 32'(4 * i));
      bus.bellek_veri_gecerli_i = 1'b1;
      bus.getir_iptal_i         = (i == iptal_beat);
      @(posedge clk);
      #1;
      bus.bellek_veri_gecerli_i = 1'b0;
      bus.getir_iptal_i         = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.getir_hazir_o !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (bus.getir_hazir_o !== 1'b1) begin
      fails++;
      $display("FAIL wait_idle got=%b expected=1 (timeout)", bus.getir_hazir_o);
    end
  endtask

  task automatic check_miss_started(input string nm);
    tests++;
    if (bus.bellek_gecerli_o !== 1'b1 || bus.getir_duraklat_o !== 1'b1 || bus.getir_gecerli_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_miss got bg=%b dur=%b gv=%b expected bg=1 dur=1 gv=0", nm,
               bus.bellek_gecerli_o, bus.getir_duraklat_o, bus.getir_gecerli_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests++;
    if (bus.getir_buy_o !== 32'h0 || bus.getir_gecerli_o !== 1'b0 || bus.getir_duraklat_o !== 1'b0 ||
        bus.getir_adres_kabul_o !== 1'b0 || bus.bellek_gecerli_o !== 1'b0 ||
        bus.bellek_adres_o !== 32'h0 || bus.getir_hazir_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs got buy=%h gv=%b dur=%b kab=%b bg=%b ba=%h hz=%b expected 0,0,0,0,0,0,1",
               bus.getir_buy_o, bus.getir_gecerli_o, bus.getir_duraklat_o, bus.getir_adres_kabul_o,
               bus.bellek_gecerli_o, bus.bellek_adres_o, bus.getir_hazir_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    req(32'h0000_0104, 1'b1);
    tests++;
    if (bus.getir_duraklat_o !== 1'b1 || bus.bellek_adres_o !== 32'h0000_0100 || bus.getir_gecerli_o !== 1'b0) begin
      fails++;
      $display("FAIL cold_miss_start got dur=%b ba=%h gv=%b expected 1,00000100,0",
               bus.getir_duraklat_o, bus.bellek_adres_o, bus.getir_gecerli_o);
    end
    serve_refill(32'h0000_0100, 0, -1, 1'b0);
    tests++;
    if ((cyc - acc_cyc + 1) != 6 || bus.getir_gecerli_o !== 1'b1 || bus.getir_buy_o !== 32'h22) begin
      fails++;
      $display("FAIL cold_miss_yanit got lat=%0d gv=%b buy=%h expected 6,1,00000022",
               cyc - acc_cyc + 1, bus.getir_gecerli_o, bus.getir_buy_o);
    end
    tests++;
    if (bus.getir_duraklat_o !== 1'b1) begin
      fails++;
      $display("FAIL cold_miss_yanit_stall got=%b expected=1", bus.getir_duraklat_o);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.getir_duraklat_o !== 1'b0 || bus.getir_hazir_o !== 1'b1) begin
      fails++;
      $display("FAIL cold_miss_release got dur=%b hz=%b expected 0,1", bus.getir_duraklat_o, bus.getir_hazir_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      req(32'h0000_0100 + 32'(4 * i), 1'b1);
      tests++;
      if (bus.getir_duraklat_o !== 1'b0 || bus.getir_gecerli_o !== 1'b1) begin
        fails++;
        $display("FAIL hit_stream_%0d got dur=%b gv=%b expected 0,1", i, bus.getir_duraklat_o, bus.getir_gecerli_o);
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (beklenen_q.size() != 0) begin
      fails++;
      $display("FAIL hit_stream_drain got=%0d expected=0", beklenen_q.size());
    end
  endtask

  task automatic test_conflict();
    req(32'h0000_0500, 1'b1);
    check_miss_started("conflict_fill");
    serve_refill(32'h0000_0500, 1, -1, 1'b0);
    wait_idle();
    req(32'h0000_0100, 1'b1);
    check_miss_started("conflict_evicted");
    serve_refill(32'h0000_0100, 0, -1, 1'b0);
    wait_idle();
  endtask

  task automatic test_flush();
    req(32'h0000_0208, 1'b0);
    serve_refill(32'h0000_0200, 0, 2, 1'b0);
    tests++;
    if (bus.getir_gecerli_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_yanit got=%b expected=0", bus.getir_gecerli_o);
    end
    wait_idle();
    req(32'h0000_0208, 1'b1);
    tests++;
    if (bus.getir_gecerli_o !== 1'b1 || bus.getir_duraklat_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_rehit got gv=%b dur=%b expected 1,0", bus.getir_gecerli_o, bus.getir_duraklat_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_invalidate();
    bus.getir_ps_i         = 32'h0000_0104;
    bus.getir_ps_gecerli_i = 1'b1;
    bus.gecersiz_kil_i     = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.getir_adres_kabul_o !== 1'b0) begin
      fails++;
      $display("FAIL invalidate_kabul got=%b expected=0", bus.getir_adres_kabul_o);
    end
    @(posedge clk);
    #1;
    bus.gecersiz_kil_i     = 1'b0;
    bus.getir_ps_gecerli_i = 1'b0;
    req(32'h0000_0104, 1'b1);
    check_miss_started("invalidate_rereq");
    serve_refill(32'h0000_0100, 0, -1, 1'b0);
    wait_idle();

    // Invalidate raised during a refill is deferred until the cache is idle again.
    req(32'h0000_0304, 1'b1);
    serve_refill(32'h0000_0300, 0, -1, 1'b1);
    wait_idle();
    bus.getir_ps_i         = 32'h0000_0304;
    bus.getir_ps_gecerli_i = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.getir_adres_kabul_o !== 1'b0) begin
      fails++;
      $display("FAIL pending_invalidate_kabul got=%b expected=0", bus.getir_adres_kabul_o);
    end
    @(posedge clk);
    #1;
    bus.getir_ps_gecerli_i = 1'b0;
    req(32'h0000_0304, 1'b1);
    check_miss_started("pending_invalidate_rereq");
    serve_refill(32'h0000_0300, 0, -1, 1'b0);
    wait_idle();
  endtask

  task automatic test_async_reset();
    req(32'h0000_0604, 1'b0);
    bus.bellek_hazir_i = 1'b1;
    @(posedge clk);
    #1;
    bus.bellek_hazir_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bellek_veri_i         = mem_word(32'h0000_0600 + 32'(4 * i));
      bus.bellek_veri_gecerli_i = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.bellek_veri_gecerli_i = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.bellek_gecerli_o !== 1'b0 || bus.getir_duraklat_o !== 1'b0 || bus.getir_gecerli_o !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got bg=%b dur=%b gv=%b expected 0,0,0",
               bus.bellek_gecerli_o, bus.getir_duraklat_o, bus.getir_gecerli_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req(32'h0000_0604, 1'b1);
    check_miss_started("async_reset_rereq");
    serve_refill(32'h0000_0600, 0, -1, 1'b0);
    wait_idle();
  endtask

  initial begin
    rst                       = 1'b1;
    bus.getir_ps_i            = '0;
    bus.getir_ps_gecerli_i    = 1'b0;
    bus.getir_iptal_i         = 1'b0;
    bus.gecersiz_kil_i        = 1'b0;
    bus.bellek_hazir_i        = 1'b0;
    bus.bellek_veri_i         = '0;
    bus.bellek_veri_gecerli_i = 1'b0;

    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_invalidate();
    test_async_reset();

    @(posedge clk);
    #1;
    tests++;
    if (beklenen_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d expected=0", beklenen_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
